pipe_window_acc: RTL and testbench

//  Downstream consumer of the 16-bit D result from the multiply/add pipeline stage.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_sat_add.sv | 22 ++
 rtl/pipe_window_acc.sv | 140 ++++++++++++++
 tb/tb_pipe_window_acc.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the multiply/add pipeline's downstream blocks.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    localparam int PIPE_DW = 16;
    localparam int PIPE_OW = 20;
    localparam int CNT_W   = 8;

endpackage

// File: rtl/pipe_sat_add.sv
// OW-bit unsigned adder with carry-out; clamps to all-ones when ACC_SAT_EN is defined.
module pipe_sat_add #(
    parameter int OW = 20
) (
    input  logic [OW-1:0] i_a,
    input  logic [OW-1:0] i_b,
    output logic [OW-1:0] o_sum,
    output logic          o_ovf
);

    logic [OW:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign o_ovf  = w_full[OW];

`ifdef ACC_SAT_EN
    assign o_sum = w_full[OW] ? {OW{1'b1}} : w_full[OW-1:0];
`else
    assign o_sum = w_full[OW-1:0];
`endif

endmodule

// File: rtl/pipe_window_acc.sv
// Sums each window of WIN accepted samples and hands the total out through one holding register.
// Optional sticky overflow flag and clamping add are enabled by defining ACC_SAT_EN.
module pipe_window_acc
    import pipe_pkg::*;
#(
    parameter int DW  = PIPE_DW,
    parameter int WIN = 4,
    parameter int OW  = PIPE_OW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    input  logic          out_ready
`ifdef ACC_SAT_EN
    ,
    output logic          sat
`endif
);

    acc_state_t       r_state, w_nxt_state;
    logic [OW-1:0]    r_acc, w_nxt_acc;
    logic [OW-1:0]    r_out_data, w_nxt_out_data;
    logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
    logic             r_out_valid, w_nxt_out_valid;
    logic             r_run;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_deliver;
    logic             w_start;
    logic             w_close;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [OW-1:0]    w_add_a;
    logic [OW-1:0]    w_add_b;
    logic [OW-1:0]    w_sum;
    logic             w_sat_ovf;

    // r_run keeps in_ready low until the first edge after reset is released.
    assign w_in_ready = r_run & ~clear & ((r_state != HOLD) | out_ready);
    assign w_accept   = in_valid & w_in_ready;
    assign w_deliver  = r_out_valid & out_ready;
    assign w_start    = (r_state != ACCUM);
    assign w_add_a    = w_start ? '0 : r_acc;
    assign w_add_b    = OW'(in_data);
    assign w_cnt_inc  = w_start ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_close    = (w_cnt_inc == CNT_W'(WIN));

    pipe_sat_add #(
        .OW(OW)
    ) u_add (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .o_sum (w_sum),
        .o_ovf (w_sat_ovf)
    );

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_acc       = r_acc;
        w_nxt_cnt       = r_cnt;
        w_nxt_out_data  = r_out_data;
        w_nxt_out_valid = r_out_valid;
        if (clear) begin
            w_nxt_state     = IDLE;
            w_nxt_acc       = '0;
            w_nxt_cnt       = '0;
            w_nxt_out_valid = 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (w_deliver) begin
                        w_nxt_state     = IDLE;
                        w_nxt_out_valid = 1'b0;
                    end
                end
                IDLE, ACCUM: ;
                default: w_nxt_state = IDLE;
            endcase
            // In HOLD an accept implies a deliver, so a new window may open here.
            if (w_accept) begin
                if (w_close) begin
                    w_nxt_state     = HOLD;
                    w_nxt_out_data  = w_sum;
                    w_nxt_out_valid = 1'b1;
                    w_nxt_acc       = '0;
                    w_nxt_cnt       = '0;
                end else begin
                    w_nxt_state = ACCUM;
                    w_nxt_acc   = w_sum;
                    w_nxt_cnt   = w_cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_acc       <= w_nxt_acc;
            r_cnt       <= w_nxt_cnt;
            r_out_data  <= w_nxt_out_data;
            r_out_valid <= w_nxt_out_valid;
            r_run       <= 1'b1;
        end
    end

`ifdef ACC_SAT_EN
    logic r_sat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat <= 1'b0;
        end else if (w_accept && w_sat_ovf) begin
            r_sat <= 1'b1;
        end
    end

    assign sat = r_sat;
`else
    logic w_unused;
    assign w_unused = w_sat_ovf;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_pipe_window_acc.sv
// Directed bench for pipe_window_acc: a 20-bit and a 17-bit instance share one stimulus stream
// and are checked every cycle against a sample-counting model plus hand-computed totals.
module tb_pipe_window_acc;

    localparam int WIN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = 16'd0;

    logic        rdy20, ov20, rdy17, ov17;
    logic [19:0] od20;
    logic [16:0] od17;
`ifdef ACC_SAT_EN
    logic        sat20, sat17;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_window_acc #(.DW(16), .WIN(WIN), .OW(20)) u_dut20 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy20),
        .out_valid (ov20),
        .out_data  (od20),
        .out_ready (out_ready)
`ifdef ACC_SAT_EN
        ,
        .sat       (sat20)
`endif
    );

    pipe_window_acc #(.DW(16), .WIN(WIN), .OW(17)) u_dut17 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy17),
        .out_valid (ov17),
        .out_data  (od17),
        .out_ready (out_ready)
`ifdef ACC_SAT_EN
        ,
        .sat       (sat17)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] maxOf(input int ow);
        return (32'd1 << ow) - 32'd1;
    endfunction

    function automatic logic [31:0] modelAdd(input logic [31:0] a, input logic [15:0] x, input int ow);
        logic [31:0] full;
        full = a + 32'(x);
`ifdef ACC_SAT_EN
        return (full > maxOf(ow)) ? maxOf(ow) : full;
`else
        return full & maxOf(ow);
`endif
    endfunction

    // Model: counts accepted samples, keeps a true running sum per width, one pending result.
    int          m_n;
    logic [31:0] m_acc20, m_acc17, m_od20, m_od17;
    bit          m_ov, m_run, m_rdy, m_take, m_sat20, m_sat17;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n = 0; m_acc20 = 0; m_acc17 = 0; m_od20 = 0; m_od17 = 0;
            m_ov = 0; m_run = 0; m_sat20 = 0; m_sat17 = 0;
        end else begin
            m_rdy  = m_run && !clear && (!m_ov || out_ready);
            m_take = in_valid && m_rdy;
            if (clear) begin
                m_n = 0; m_acc20 = 0; m_acc17 = 0; m_ov = 0;
            end else begin
                if (m_ov && out_ready) m_ov = 0;
                if (m_take) begin
                    if (m_acc20 + 32'(in_data) > maxOf(20)) m_sat20 = 1;
                    if (m_acc17 + 32'(in_data) > maxOf(17)) m_sat17 = 1;
                    m_acc20 = modelAdd(m_acc20, in_data, 20);
                    m_acc17 = modelAdd(m_acc17, in_data, 17);
                    m_n++;
                    if (m_n == WIN) begin
                        m_od20 = m_acc20; m_od17 = m_acc17; m_ov = 1;
                        m_n = 0; m_acc20 = 0; m_acc17 = 0;
                    end
                end
            end
            m_run = 1;
        end
    end

    always @(negedge clk) begin
        logic exp_rdy;
        exp_rdy = m_run && !clear && (!m_ov || out_ready);
        checkOutput("in_ready20",  32'(rdy20), 32'(exp_rdy));
        checkOutput("out_valid20", 32'(ov20),  32'(m_ov));
        checkOutput("out_data20",  32'(od20),  m_od20);
        checkOutput("in_ready17",  32'(rdy17), 32'(exp_rdy));
        checkOutput("out_valid17", 32'(ov17),  32'(m_ov));
        checkOutput("out_data17",  32'(od17),  m_od17);
`ifdef ACC_SAT_EN
        checkOutput("sat20", 32'(sat20), 32'(m_sat20));
        checkOutput("sat17", 32'(sat17), 32'(m_sat17));
`endif
    end

    task automatic applyStimulus(input bit v, input logic [15:0] d, input bit c, input bit r);
        in_valid  = v;
        in_data   = d;
        clear     = c;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        checkOutput("reset in_ready", 32'(rdy20), 32'd0);
        checkOutput("reset out_valid", 32'(ov20), 32'd0);
        checkOutput("reset out_data", 32'(od20), 32'd0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready after release", 32'(rdy20), 32'd1);

        // Single window with the consumer always ready.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b1);
        checkOutput("t1 out_valid", 32'(ov20), 32'd1);
        checkOutput("t1 out_data", 32'(od20), 32'd10);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        checkOutput("t1 one-cycle valid", 32'(ov20), 32'd0);

        // Backpressure: result is held and offered samples are ignored.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2 in_ready", 32'(rdy20), 32'd0);
            applyStimulus(1'b1, 16'd100, 1'b0, 1'b0);
            checkOutput("t2 held data", 32'(od20), 32'd10);
            checkOutput("t2 held valid", 32'(ov20), 32'd1);
        end
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        checkOutput("t2 delivered", 32'(ov20), 32'd0);

        // Back-to-back windows at full rate.
        for (int i = 0; i < 8; i++) begin
            checkOutput("t3 no bubble", 32'(rdy20), 32'd1);
            applyStimulus(1'b1, 16'h0F84, 1'b0, 1'b1);
            if (i == 3 || i == 7) begin
                checkOutput("t3 valid", 32'(ov20), 32'd1);
                checkOutput("t3 total", 32'(od20), 32'h3E10);
            end
        end
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);

        // Narrow accumulator overflow.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b1);
        checkOutput("t4 wide total", 32'(od20), 32'h3FFFC);
`ifdef ACC_SAT_EN
        checkOutput("t4 narrow total", 32'(od17), 32'h1FFFF);
        checkOutput("t4 sat17", 32'(sat17), 32'd1);
        checkOutput("t4 sat20", 32'(sat20), 32'd0);
`else
        checkOutput("t4 narrow total", 32'(od17), 32'h1FFFC);
`endif
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);

        // Clear mid-window, with a sample offered in the clear cycle.
        applyStimulus(1'b1, 16'd9, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'd9, 1'b0, 1'b1);
        checkOutput("t5 in_ready during clear", 32'(rdy20 & ~clear), 32'd1);
        applyStimulus(1'b1, 16'd7, 1'b1, 1'b1);
        checkOutput("t5 no stray valid", 32'(ov20), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'd5, 1'b0, 1'b1);
        checkOutput("t5 total20", 32'(od20), 32'd20);
        checkOutput("t5 total17", 32'(od17), 32'd20);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);

        // Asynchronous reset between edges in the middle of a window.
        applyStimulus(1'b1, 16'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'd1, 1'b0, 1'b1);
        in_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        checkOutput("t6 in_ready", 32'(rdy20), 32'd0);
        checkOutput("t6 out_valid", 32'(ov20), 32'd0);
        checkOutput("t6 out_data20", 32'(od20), 32'd0);
        checkOutput("t6 out_data17", 32'(od17), 32'd0);
`ifdef ACC_SAT_EN
        checkOutput("t6 sat17", 32'(sat17), 32'd0);
`endif
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'd1, 1'b0, 1'b1);
        checkOutput("t6 total", 32'(od20), 32'd4);
        checkOutput("t6 valid", 32'(ov20), 32'd1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
